// File: rtl/data_write_buffer_pkg.sv
// Shared types and constants for the posted-write buffer between the store unit
// and the AXI data-side write channel.
package data_write_buffer_pkg;

  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT_B = 2'd2
  } state_e;

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  wen;
    logic [31:0] data;
  } entry_t;

  function automatic logic [31:0] entry_byte_addr(input entry_t e);
    return {e.addr, 2'b00};
  endfunction

endpackage

// File: rtl/data_write_buffer_if.sv
// AXI4 write-channel bundle (AW, W, B) driven by the write buffer as master.
interface data_write_buffer_if;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/data_write_buffer_store_fifo.sv
// In-order store queue with occupancy count and a parallel word-address
// compare across every live entry (the in-flight head included).
module data_write_buffer_store_fifo
  import data_write_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  entry_t           push_entry,
  input  logic [29:0]      ld_word,
  output entry_t           head,
  output logic [CNT_W-1:0] count,
  output logic             ld_hit
);

  entry_t           mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             hit_s;
  logic [PTR_W-1:0] offs_s;

  // Pointer and occupancy tracking; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; payload needs no reset since liveness comes from the count.
  always_ff @(posedge clk) begin
    if (push) mem_r[wr_ptr_r] <= push_entry;
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    hit_s  = 1'b0;
    offs_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs_s = PTR_W'(i) - rd_ptr_r;
      if (({1'b0, offs_s} < count_r) && (mem_r[i].addr == ld_word)) begin
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  assign head   = mem_r[rd_ptr_r];
  assign count  = count_r;
  assign ld_hit = hit_s;

endmodule

// File: rtl/data_write_buffer.sv
// Posted-write buffer: queues byte-enabled word stores and drains them in order
// as single-beat AXI4 writes with one transaction outstanding.
module data_write_buffer
  import data_write_buffer_pkg::*;
#(
  parameter int         DEPTH  = 4,
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                st_valid,
  input  logic [3:0]          st_wen,
  input  logic [31:0]         st_addr,
  input  logic [31:0]         st_wdata,
  output logic                st_ready,
  input  logic [31:0]         ld_addr,
  output logic                ld_hit,
  output logic                buf_empty,
  data_write_buffer_if.master axi
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  entry_t           head_s;
  entry_t           push_entry_s;
  logic [CNT_W-1:0] count_s;
  logic             st_ready_s;
  logic             push_s;
  logic             pop_s;
  logic             aw_hs_s;
  logic             w_hs_s;
  logic             aw_fin_s;
  logic             w_fin_s;
  logic             unused_s;

  state_e state_r;
  logic   aw_done_r;
  logic   w_done_r;
  logic   awvalid_r;
  logic   wvalid_r;
  logic   bready_r;

  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
  assign st_ready_s   = (count_s != CNT_W'(DEPTH));
  assign push_s       = st_valid && st_ready_s && (st_wen != 4'b0000);
  assign pop_s        = (state_r == WAIT_B) && bready_r && axi.bvalid;
  assign push_entry_s = '{addr: st_addr[31:2], wen: st_wen, data: st_wdata};

  assign aw_hs_s  = awvalid_r && axi.awready;
  assign w_hs_s   = wvalid_r && axi.wready;
  assign aw_fin_s = aw_done_r || aw_hs_s;
  assign w_fin_s  = w_done_r || w_hs_s;

  data_write_buffer_store_fifo #(.DEPTH(DEPTH)) u_store_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_s),
    .pop       (pop_s),
    .push_entry(push_entry_s),
    .ld_word   (ld_addr[31:2]),
    .head      (head_s),
    .count     (count_s),
    .ld_hit    (ld_hit)
  );

  // Transaction sequencer: AW and W complete independently, then wait for B.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= IDLE;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (count_s != CNT_W'(0)) begin
            state_r   <= SEND;
            awvalid_r <= 1'b1;
            wvalid_r  <= 1'b1;
          end
          aw_done_r <= 1'b0;
          w_done_r  <= 1'b0;
          bready_r  <= 1'b0;
        end
        SEND: begin
          if (aw_fin_s && w_fin_s) begin
            state_r   <= WAIT_B;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b1;
          end else begin
            aw_done_r <= aw_fin_s;
            w_done_r  <= w_fin_s;
            awvalid_r <= !aw_fin_s;
            wvalid_r  <= !w_fin_s;
          end
        end
        WAIT_B: begin
          if (axi.bvalid) begin
            bready_r <= 1'b0;
            if (count_s > CNT_W'(1)) begin
              state_r   <= SEND;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          aw_done_r <= 1'b0;
          w_done_r  <= 1'b0;
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          bready_r  <= 1'b0;
        end
      endcase
    end
  end

  // Payload comes straight from the head, which cannot move until B is taken.
  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = entry_byte_addr(head_s);
  assign axi.awlen   = LEN_SINGLE;
  assign axi.awsize  = SIZE_4B;
  assign axi.awburst = BURST_INCR;
  assign axi.awvalid = awvalid_r;
  assign axi.wid     = AXI_ID;
  assign axi.wdata   = head_s.data;
  assign axi.wstrb   = head_s.wen;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_r;
  assign axi.bready  = bready_r;

  assign st_ready  = st_ready_s;
  assign buf_empty = (count_s == CNT_W'(0));
  assign unused_s  = ^{axi.bid, axi.bresp, st_addr[1:0]};

endmodule

// File: tb/tb_data_write_buffer.sv
// Directed, table-driven bench for data_write_buffer with a logging AXI slave.
module tb_data_write_buffer;

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_awaddr;
    logic        exp_push;
  } st_vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        exp_hit;
  } ld_vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
  } aw_rec_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic [3:0]  id;
  } w_rec_t;

  logic        clk;
  logic        resetn;
  logic        st_valid;
  logic [3:0]  st_wen;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic        st_ready;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic        buf_empty;
  logic        aw_en;
  logic        w_en;
  logic        b_en;

  int checks;
  int errors;

  aw_rec_t aw_q [$];
  w_rec_t  w_q [$];
  int      b_cnt     = 0;
  int      hold_viol = 0;
  logic        aw_pend;
  logic        w_pend;
  logic [31:0] aw_prev;
  logic [31:0] w_prev;

  data_write_buffer_if axi ();

  data_write_buffer #(.DEPTH(4), .AXI_ID(4'd1)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .st_valid (st_valid),
    .st_wen   (st_wen),
    .st_addr  (st_addr),
    .st_wdata (st_wdata),
    .st_ready (st_ready),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .buf_empty(buf_empty),
    .axi      (axi.master)
  );

  assign axi.awready = aw_en;
  assign axi.wready  = w_en;
  assign axi.bvalid  = b_en & axi.bready;
  assign axi.bid     = 4'd1;
  assign axi.bresp   = 2'b00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Slave-side logger: records handshakes and flags valid/payload instability.
  always @(posedge clk) begin
    if (!resetn) begin
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else begin
      if (axi.awvalid && axi.awready)
        aw_q.push_back('{axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awid});
      if (axi.wvalid && axi.wready)
        w_q.push_back('{axi.wdata, axi.wstrb, axi.wlast, axi.wid});
      if (axi.bvalid && axi.bready)
        b_cnt <= b_cnt + 1;
      hold_viol <= hold_viol
                 + int'(aw_pend && (!axi.awvalid || axi.awaddr != aw_prev))
                 + int'(w_pend && (!axi.wvalid || axi.wdata != w_prev));
      aw_pend <= axi.awvalid && !axi.awready;
      w_pend  <= axi.wvalid && !axi.wready;
      aw_prev <= axi.awaddr;
      w_prev  <= axi.wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_empty(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (buf_empty) break;
      tick();
    end
    chk(name, 32'(buf_empty), 32'd1);
  endtask

  task automatic push_one(input logic [31:0] addr, input logic [31:0] data);
    st_valid = 1'b1;
    st_wen   = 4'b1111;
    st_addr  = addr;
    st_wdata = data;
    tick();
    st_valid = 1'b0;
    st_wen   = 4'b0000;
  endtask

  st_vec_t st_tab [5];
  ld_vec_t ld_tab [5];
  int base_aw;
  int base_w;
  int base_b;

  initial begin
    checks = 0;
    errors = 0;
    st_tab[0] = '{4'b0100, 32'h1000_0006, 32'h00AB_0000, 32'h1000_0004, 1'b1};
    st_tab[1] = '{4'b1111, 32'h8000_0000, 32'hDEAD_BEEF, 32'h8000_0000, 1'b1};
    st_tab[2] = '{4'b0011, 32'hFFFF_FFFE, 32'h0000_1234, 32'hFFFF_FFFC, 1'b1};
    st_tab[3] = '{4'b0000, 32'h1234_5678, 32'h5555_5555, 32'h0000_0000, 1'b0};
    st_tab[4] = '{4'b1000, 32'h0000_0003, 32'h7700_0000, 32'h0000_0000, 1'b1};
    ld_tab[0] = '{32'h2000_0013, 1'b1};
    ld_tab[1] = '{32'h2000_0014, 1'b0};
    ld_tab[2] = '{32'h2000_0010, 1'b1};
    ld_tab[3] = '{32'h2000_000C, 1'b0};
    ld_tab[4] = '{32'h3000_0010, 1'b0};

    resetn = 1'b0; st_valid = 1'b0; st_wen = 4'b0000; st_addr = 32'h0;
    st_wdata = 32'h0; ld_addr = 32'h0; aw_en = 1'b0; w_en = 1'b0; b_en = 1'b0;
    repeat (2) tick();
    chk("rst_awvalid",   32'(axi.awvalid), 32'd0);
    chk("rst_wvalid",    32'(axi.wvalid),  32'd0);
    chk("rst_bready",    32'(axi.bready),  32'd0);
    chk("rst_st_ready",  32'(st_ready),    32'd1);
    chk("rst_buf_empty", 32'(buf_empty),   32'd1);
    chk("rst_ld_hit",    32'(ld_hit),      32'd0);
    resetn = 1'b1;
    aw_en = 1'b1; w_en = 1'b1; b_en = 1'b1;
    tick();

    // Single stores through a zero-wait slave.
    for (int v = 0; v < 5; v++) begin
      base_aw = aw_q.size(); base_w = w_q.size(); base_b = b_cnt;
      st_valid = 1'b1; st_wen = st_tab[v].wen;
      st_addr = st_tab[v].addr; st_wdata = st_tab[v].data;
      tick();
      st_valid = 1'b0; st_wen = 4'b0000;
      if (st_tab[v].exp_push) begin
        chk("vec_count1_nonempty", 32'(buf_empty), 32'd0);
        chk("vec_idle_awvalid",    32'(axi.awvalid), 32'd0);
        tick();
        chk("vec_send_awvalid", 32'(axi.awvalid), 32'd1);
        chk("vec_send_wvalid",  32'(axi.wvalid), 32'd1);
        chk("vec_awaddr", axi.awaddr, st_tab[v].exp_awaddr);
        chk("vec_wstrb",  32'(axi.wstrb), 32'(st_tab[v].wen));
        chk("vec_wdata",  axi.wdata, st_tab[v].data);
        tick();
        chk("vec_waitb_bready",  32'(axi.bready), 32'd1);
        chk("vec_waitb_awvalid", 32'(axi.awvalid), 32'd0);
        tick();
        chk("vec_retired_empty", 32'(buf_empty), 32'd1);
        chk("vec_retired_bready", 32'(axi.bready), 32'd0);
        chk("vec_aw_count", 32'(aw_q.size() - base_aw), 32'd1);
        chk("vec_w_count",  32'(w_q.size() - base_w), 32'd1);
        chk("vec_b_count",  32'(b_cnt - base_b), 32'd1);
        if (aw_q.size() > base_aw && w_q.size() > base_w) begin
          chk("vec_log_awaddr",  aw_q[base_aw].addr, st_tab[v].exp_awaddr);
          chk("vec_log_awlen",   32'(aw_q[base_aw].len), 32'd0);
          chk("vec_log_awsize",  32'(aw_q[base_aw].size), 32'd2);
          chk("vec_log_awburst", 32'(aw_q[base_aw].burst), 32'd1);
          chk("vec_log_awid",    32'(aw_q[base_aw].id), 32'd1);
          chk("vec_log_wdata",   w_q[base_w].data, st_tab[v].data);
          chk("vec_log_wstrb",   32'(w_q[base_w].strb), 32'(st_tab[v].wen));
          chk("vec_log_wlast",   32'(w_q[base_w].last), 32'd1);
          chk("vec_log_wid",     32'(w_q[base_w].id), 32'd1);
        end
      end else begin
        for (int c = 0; c < 3; c++) begin
          chk("vec_cancel_empty",   32'(buf_empty), 32'd1);
          chk("vec_cancel_awvalid", 32'(axi.awvalid), 32'd0);
          tick();
        end
        chk("vec_cancel_no_aw", 32'(aw_q.size() - base_aw), 32'd0);
      end
    end

    // Fill to capacity with AW stalled; the fifth store must be refused.
    aw_en = 1'b0; w_en = 1'b0;
    base_aw = aw_q.size(); base_w = w_q.size();
    for (int k = 0; k < 5; k++) begin
      if (k == 4) chk("full_st_ready", 32'(st_ready), 32'd0);
      st_valid = 1'b1; st_wen = 4'b1111;
      st_addr = 32'h4000_0000 + 32'(k * 4); st_wdata = 32'hC0DE_0000 + 32'(k);
      tick();
    end
    st_valid = 1'b0; st_wen = 4'b0000;
    chk("full_still_full", 32'(st_ready), 32'd0);
    ld_addr = 32'h4000_0010; #1;
    chk("full_fifth_absent", 32'(ld_hit), 32'd0);
    ld_addr = 32'h4000_000C; #1;
    chk("full_fourth_present", 32'(ld_hit), 32'd1);
    tick();
    aw_en = 1'b1; w_en = 1'b1;
    wait_empty("full_drain", 60);
    chk("full_aw_count", 32'(aw_q.size() - base_aw), 32'd4);
    chk("full_w_count",  32'(w_q.size() - base_w), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (aw_q.size() > base_aw + k && w_q.size() > base_w + k) begin
        chk("full_order_awaddr", aw_q[base_aw + k].addr, 32'h4000_0000 + 32'(k * 4));
        chk("full_order_wdata",  w_q[base_w + k].data, 32'hC0DE_0000 + 32'(k));
      end
    end

    // W accepted three cycles ahead of AW.
    aw_en = 1'b0; w_en = 1'b0;
    base_aw = aw_q.size(); base_w = w_q.size(); base_b = b_cnt;
    push_one(32'h5000_0008, 32'h1357_9BDF);
    tick();
    chk("split_awvalid0", 32'(axi.awvalid), 32'd1);
    chk("split_wvalid0",  32'(axi.wvalid), 32'd1);
    w_en = 1'b1;
    tick();
    chk("split_wvalid_drop", 32'(axi.wvalid), 32'd0);
    chk("split_awvalid_hold", 32'(axi.awvalid), 32'd1);
    tick();
    tick();
    chk("split_awvalid_hold3", 32'(axi.awvalid), 32'd1);
    chk("split_no_bready",     32'(axi.bready), 32'd0);
    aw_en = 1'b1;
    tick();
    chk("split_bready",  32'(axi.bready), 32'd1);
    chk("split_awvalid", 32'(axi.awvalid), 32'd0);
    tick();
    chk("split_empty",   32'(buf_empty), 32'd1);
    chk("split_b_count", 32'(b_cnt - base_b), 32'd1);
    chk("split_w_count", 32'(w_q.size() - base_w), 32'd1);
    chk("split_aw_count", 32'(aw_q.size() - base_aw), 32'd1);

    // Load-alias detection against a pending store.
    aw_en = 1'b0; w_en = 1'b0;
    push_one(32'h2000_0010, 32'hAAAA_5555);
    tick();
    for (int v = 0; v < 5; v++) begin
      ld_addr = ld_tab[v].addr; #1;
      chk("ld_hit_vec", 32'(ld_hit), 32'(ld_tab[v].exp_hit));
      tick();
    end
    aw_en = 1'b1; w_en = 1'b1;
    wait_empty("ld_drain", 20);
    ld_addr = 32'h2000_0013; #1;
    chk("ld_hit_cleared", 32'(ld_hit), 32'd0);
    tick();

    // Reset asserted in WAIT_B with two entries queued.
    b_en = 1'b0;
    push_one(32'h6000_0000, 32'h0000_0001);
    push_one(32'h6000_0004, 32'h0000_0002);
    tick();
    chk("rstmid_bready_pre", 32'(axi.bready), 32'd1);
    chk("rstmid_nonempty",   32'(buf_empty), 32'd0);
    resetn = 1'b0; #1;
    chk("rstmid_awvalid",   32'(axi.awvalid), 32'd0);
    chk("rstmid_wvalid",    32'(axi.wvalid), 32'd0);
    chk("rstmid_bready",    32'(axi.bready), 32'd0);
    chk("rstmid_buf_empty", 32'(buf_empty), 32'd1);
    chk("rstmid_st_ready",  32'(st_ready), 32'd1);
    tick();
    resetn = 1'b1; b_en = 1'b1;
    tick();
    tick();
    chk("rstmid_stays_idle", 32'(axi.awvalid), 32'd0);
    chk("hold_stability", 32'(hold_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_write_buffer.md
# data_write_buffer

Posted-write buffer between the store unit and the AXI data-side write channel. Accepts one byte-enabled word store per cycle from the MEM stage, queues it in a DEPTH-entry FIFO, and drains entries in order as single-beat AXI4 write transactions, one outstanding at a time. Provides a load-address hit flag so the pipeline can stall loads that alias a pending store.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2
- AXI_ID, 4'd1: constant awid/wid value
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- st_valid  in  1  store request from store unit
- st_wen  in  4  byte enables (low 4 bits of store-unit write enable)
- st_addr  in  32  store byte address
- st_wdata  in  32  lane-aligned store data
- st_ready  out  1  buffer can accept a store this cycle
- ld_addr  in  32  current load address
- ld_hit  out  1  a valid entry matches ld_addr[31:2]
- buf_empty  out  1  no entries, no transaction in flight
- awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/8/3/2/1  AXI AW
- awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI W
- wready  in  1
- bid/bresp  in  4/2;  bvalid  in  1;  bready  out  1  AXI B

## Operation
- Push: st_valid && st_ready && st_wen!=0 writes {addr[31:2], wen, wdata} at tail. st_wen==0 is dropped silently (cancelled store).
- st_ready = (count != DEPTH), from registered count only; a push is refused at full even if a pop occurs the same cycle.
- FSM states IDLE, SEND, WAIT_B.
  - IDLE: count!=0 → SEND.
  - SEND: awvalid = !aw_done, wvalid = !w_done, both driven from head entry. aw_done set on awvalid&&awready, w_done on wvalid&&wready; either order, or same cycle. When both complete (including completion this cycle) → WAIT_B, flags cleared.
  - WAIT_B: bready=1; on bvalid, pop head; → SEND if count>1, else IDLE.
- AXI fields: awaddr={head.addr,2'b00}, awlen=0, awsize=3'b010, awburst=2'b01, wstrb=head.wen, wlast=1, awid=wid=AXI_ID. bresp and bid ignored.
- Head stays in FIFO until B accepted; ld_hit compares all valid entries, in-flight included.
- buf_empty = (count==0).
- Simultaneous push and pop (not full): both take effect, count unchanged.
- Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

## Timing
- Reset: state=IDLE, count=0, pointers=0, aw_done=w_done=0; outputs awvalid=wvalid=bready=0, st_ready=1, buf_empty=1, ld_hit=0.
- Reset mid-transaction abandons it; valids drop asynchronously with reset.
- Push at edge t0 → count=1 after t0; SEND entered at t1; awvalid/wvalid high after t1.
- awready=wready=1 and bvalid the next cycle: store retired 3 edges after push.
- Back-to-back stores with zero-wait slave: one retire every 2 cycles.
- ld_hit, st_ready, buf_empty are combinational from registers; ld_hit is also combinational from ld_addr.
- awvalid/wvalid, once high, hold with stable payload until handshake.

## Structure
- Shared package: AXI constants (SIZE_4B, BURST_INCR), FSM state enum, entry struct {addr[29:0], wen[3:0], data[31:0]}.
- Sub-module store_fifo: storage, pointers, count, parallel address compare for ld_hit; top holds FSM and AXI drive.

## Test plan
- Single store wen=4'b0100, addr=0x1000_0006, data=0x00AB_0000, ready slave → one AW awaddr=0x1000_0004, wstrb=4'b0100, wdata=0x00AB_0000; buf_empty=1 after B.
- Push 5 stores with awready held low → st_ready=0 after 4th; 5th refused; after release, 4 writes issued in push order.
- wready before awready by 3 cycles → wvalid drops after W handshake, awvalid holds; one B pops one entry.
- Pending store at 0x2000_0010, ld_addr=0x2000_0013 → ld_hit=1; ld_addr=0x2000_0014 → 0; ld_hit clears after B.
- st_valid with st_wen=0 → no push, count unchanged, no AXI activity.
- resetn low while in WAIT_B with 2 entries → awvalid=wvalid=bready=0, buf_empty=1, st_ready=1 immediately.
